mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Single-port memory arbiter between the core's instruction-fetch stage and data-memory stage. Both requesters share one synchronous memory port with a fixed read/write latency. The arbiter grants one access at a time with data-over-fetch priority, bounded by a starvation guard. It tracks the single outstanding access and routes the response back to its owner.

## Interface
Parameters:
- MEM_LATENCY, 2, cycles from the issue cycle to the cycle mem_rdata is valid; legal range 1..15.
- STARVE_LIMIT, 4, consecutive data grants taken while fetch is pending before fetch is forced; legal range 1..15.

Ports:
- CLK  in  1  clock; all state updates on the rising edge.
- RESET  in  1  synchronous, active-high reset.
- if_req  in  1  fetch request; held with if_addr until if_gnt.
- if_addr  in  32  fetch word address.
- if_gnt  out  1  fetch request accepted this cycle.
- if_rvalid  out  1  fetch response valid this cycle.
- if_rdata  out  32  fetch response data.
- dm_req  in  1  data request; held with its payload until dm_gnt.
- dm_we  in  1  1 = write, 0 = read.
- dm_addr  in  32  data address.
- dm_wdata  in  32  write data.
- dm_be  in  4  byte enables.
- dm_gnt  out  1  data request accepted this cycle.
- dm_rvalid  out  1  data response (read data or write completion).
- dm_rdata  out  32  read data.
- mem_en  out  1  memory access issue strobe.
- mem_we  out  1  memory write enable.
- mem_addr  out  32  memory address.
- mem_wdata  out  32  memory write data.
- mem_be  out  4  memory byte enables (4'hF for fetch).
- mem_rdata  in  32  memory read data, valid MEM_LATENCY cycles after issue.
- busy  out  1  an access is outstanding (state is WAIT or RESP).

## Operation
- FSM states are IDLE, WAIT and RESP. Registers:
  - owner (0 = fetch, 1 = data);
  - cnt, 4 bits;
  - starve, 4 bits.
- Arbitration runs only in IDLE and RESP (the "issue-capable" states):
  - Only one request pending: grant it.
  - Both pending and starve < STARVE_LIMIT: grant data.
  - Both pending and starve == STARVE_LIMIT: grant fetch.
- The grant decision is combinational on the current req inputs. A requester that drops req before its grant is simply not granted.
- In a grant cycle the arbiter:
  - asserts exactly one gnt;
  - drives mem_en=1 and the granted payload onto mem_* (fetch: mem_we=0, mem_be=4'hF);
  - registers owner.
- mem_* drive all zeros in every cycle without a grant.
- Starvation counter:
  - A data grant while if_req=1: starve increments, saturating at STARVE_LIMIT.
  - Any fetch grant: starve clears to 0.
  - A data grant while if_req=0: starve holds.
- Transitions:
  - IDLE, no request: stay in IDLE.
  - Issue-capable state with a grant and MEM_LATENCY==1: go to RESP.
  - Issue-capable state with a grant and MEM_LATENCY>1: go to WAIT, loading cnt=MEM_LATENCY-2.
  - WAIT with cnt!=0: decrement cnt and stay. WAIT with cnt==0: go to RESP.
  - RESP with no grant: go to IDLE.
- In RESP the owner's rvalid=1 and the owner's rdata=mem_rdata. The non-owner's rvalid and rdata are 0.
- A write also produces rvalid in RESP. Its rdata is don't-care.
- rdata outputs are 0 whenever the matching rvalid=0.
- RESP is issue-capable, so a new grant can coincide with the previous response. In that cycle the owner register updates at the clock edge; the response in the current cycle uses the old owner.

## Timing
- Reset: on a RESET-high edge the FSM goes to IDLE and owner, cnt and starve clear.
  - While in IDLE after reset, all outputs are 0: gnt, rvalid, rdata, mem_*, busy.
  - Reset mid-access abandons the in-flight response (no rvalid ever issues). A requester whose grant was already given must re-request.
- A grant in cycle T produces mem_en in cycle T and rvalid in cycle T+MEM_LATENCY.
- Sustained throughput is one access per MEM_LATENCY cycles. A grant may occur in cycle T+MEM_LATENCY.
- No grant occurs in WAIT. Requests presented there stall until the next RESP or IDLE cycle.
- busy=1 from cycle T+1 through T+MEM_LATENCY inclusive.
- Requests must not be asserted during RESET. Any that are are ignored.

## Test plan
- **Reset.** With MEM_LATENCY=2, hold RESET for 2 cycles while if_req=1. Required: all outputs are 0. if_gnt rises in the first cycle after RESET falls.
- **Single fetch.** Drive if_addr=32'h10 in cycle T; memory returns 32'h00500093. Required:
  - cycle T: if_gnt=1, mem_addr=32'h10, mem_be=4'hF;
  - cycle T+2: if_rvalid=1, if_rdata=32'h00500093;
  - dm_rvalid=0 throughout.
- **Simultaneous requests.** In cycle T, if_req=1 and dm_req=1 with a dm read of 32'h200. Required:
  - cycle T: dm_gnt=1, mem_addr=32'h200;
  - cycle T+2: dm_rvalid=1 together with if_gnt=1 and mem_addr=if_addr.
- **Starvation guard.** Hold if_req and dm_req continuously with STARVE_LIMIT=4. Required:
  - grant sequence D,D,D,D,I,D,D,D,D,I;
  - starve reads 4 at each fetch grant, then 0 after it.
- **Write.** dm_we=1, dm_addr=32'h40, dm_wdata=32'hDEADBEEF, dm_be=4'b0011. Required:
  - cycle T: mem_we=1 and mem_be=4'b0011;
  - cycle T+2: dm_rvalid=1;
  - a later read of 32'h40 returns 32'h0000BEEF over a zeroed memory.
- **Reset mid-access.** Grant a fetch in cycle T, then assert RESET in cycle T+1. Required: no if_rvalid in T+2; busy=0 and the FSM is in IDLE after the reset edge.

Source files
------------

// File: rtl/mem_arbiter.sv
// Single-port memory arbiter: instruction fetch vs data memory, data-first
// priority with a starvation guard, one outstanding access, response routed to its owner.
module mem_arbiter #(
   parameter int MEM_LATENCY  = 2,
   parameter int STARVE_LIMIT = 4
) (
   input  logic        CLK,
   input  logic        RESET,
   input  logic        if_req,
   input  logic [31:0] if_addr,
   output logic        if_gnt,
   output logic        if_rvalid,
   output logic [31:0] if_rdata,
   input  logic        dm_req,
   input  logic        dm_we,
   input  logic [31:0] dm_addr,
   input  logic [31:0] dm_wdata,
   input  logic [3:0]  dm_be,
   output logic        dm_gnt,
   output logic        dm_rvalid,
   output logic [31:0] dm_rdata,
   output logic        mem_en,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic [3:0]  mem_be,
   input  logic [31:0] mem_rdata,
   output logic        busy
);

   typedef enum logic [1:0] {S_IDLE = 2'd0, S_WAIT = 2'd1, S_RESP = 2'd2} state_t;

   localparam logic [3:0] CNT_LOAD   = (MEM_LATENCY > 1) ? 4'(MEM_LATENCY - 2) : 4'd0;
   localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);

   state_t      r_state;
   logic        r_owner;
   logic [3:0]  r_cnt;
   logic [3:0]  r_starve;
   logic        r_busy;

   logic        w_issue;
   logic        w_gnt_dm;
   logic        w_gnt_if;
   logic        w_resp;

   // Requests seen while RESET is high are ignored, so arbitration is gated by it.
   assign w_issue  = !RESET && (r_state == S_IDLE || r_state == S_RESP);
   assign w_gnt_dm = w_issue && dm_req && (!if_req || (r_starve < STARVE_MAX));
   assign w_gnt_if = w_issue && if_req && !w_gnt_dm;
   assign w_resp   = !RESET && (r_state == S_RESP);

   assign if_gnt    = w_gnt_if;
   assign dm_gnt    = w_gnt_dm;

   // The response in RESP belongs to the owner latched at the previous grant.
   assign if_rvalid = w_resp && !r_owner;
   assign dm_rvalid = w_resp &&  r_owner;
   assign if_rdata  = if_rvalid ? mem_rdata : 32'd0;
   assign dm_rdata  = dm_rvalid ? mem_rdata : 32'd0;

   assign mem_en    = w_gnt_if || w_gnt_dm;
   assign mem_we    = w_gnt_dm && dm_we;
   assign mem_addr  = w_gnt_dm ? dm_addr  : (w_gnt_if ? if_addr : 32'd0);
   assign mem_wdata = w_gnt_dm ? dm_wdata : 32'd0;
   assign mem_be    = w_gnt_dm ? dm_be    : (w_gnt_if ? 4'hF : 4'h0);

   assign busy      = r_busy;

   always_ff @(posedge CLK) begin
      if (RESET) begin
         r_state  <= S_IDLE;
         r_owner  <= 1'b0;
         r_cnt    <= 4'd0;
         r_starve <= 4'd0;
         r_busy   <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE, S_RESP: begin
               if (w_gnt_if || w_gnt_dm) begin
                  r_owner <= w_gnt_dm;
                  r_busy  <= 1'b1;
                  if (w_gnt_if) begin
                     r_starve <= 4'd0;
                  end else if (if_req && (r_starve < STARVE_MAX)) begin
                     r_starve <= r_starve + 4'd1;
                  end
                  if (MEM_LATENCY == 1) begin
                     r_state <= S_RESP;
                  end else begin
                     r_state <= S_WAIT;
                     r_cnt   <= CNT_LOAD;
                  end
               end else begin
                  r_state <= S_IDLE;
                  r_busy  <= 1'b0;
               end
            end
            S_WAIT: begin
               if (r_cnt != 4'd0) begin
                  r_cnt <= r_cnt - 4'd1;
               end else begin
                  r_state <= S_RESP;
               end
            end
            default: begin
               r_state <= S_IDLE;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a latency-accurate memory model behind the port.
module tb_mem_arbiter;

   localparam int L = 2;

   logic        CLK = 1'b0;
   logic        RESET;
   logic        if_req;
   logic [31:0] if_addr;
   logic        if_gnt;
   logic        if_rvalid;
   logic [31:0] if_rdata;
   logic        dm_req;
   logic        dm_we;
   logic [31:0] dm_addr;
   logic [31:0] dm_wdata;
   logic [3:0]  dm_be;
   logic        dm_gnt;
   logic        dm_rvalid;
   logic [31:0] dm_rdata;
   logic        mem_en;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [3:0]  mem_be;
   logic [31:0] mem_rdata;
   logic        busy;

   int checks = 0;
   int errors = 0;

   mem_arbiter #(.MEM_LATENCY(L), .STARVE_LIMIT(4)) dut (
      .CLK(CLK), .RESET(RESET),
      .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
      .if_rvalid(if_rvalid), .if_rdata(if_rdata),
      .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
      .dm_be(dm_be), .dm_gnt(dm_gnt), .dm_rvalid(dm_rvalid), .dm_rdata(dm_rdata),
      .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_be(mem_be), .mem_rdata(mem_rdata), .busy(busy)
   );

   always #5 CLK = ~CLK;

   // Memory model: word array, read data appears L cycles after the issue cycle.
   logic [31:0] mem [0:255];
   logic [31:0] pipe [0:L-1];
   assign mem_rdata = pipe[L-1];

   always @(posedge CLK) begin
      if (RESET) begin
         for (int i = 0; i < 256; i++) mem[i] <= 32'd0;
         mem[4]   <= 32'h00500093;
         mem[5]   <= 32'h00A00113;
         mem[128] <= 32'hCAFE0001;
      end else if (mem_en && mem_we) begin
         for (int b = 0; b < 4; b++)
            if (mem_be[b]) mem[mem_addr[9:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
      end
      pipe[0] <= mem_en ? mem[mem_addr[9:2]] : 32'd0;
      for (int i = 1; i < L; i++) pipe[i] <= pipe[i-1];
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Advance one clock; inputs are then driven and outputs sampled 1ns after the edge.
   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   initial begin
      RESET = 1'b1; if_req = 1'b1; if_addr = 32'h10;
      dm_req = 1'b0; dm_we = 1'b0; dm_addr = 32'd0; dm_wdata = 32'd0; dm_be = 4'h0;

      // Reset held two cycles with a fetch pending: everything stays quiet.
      step();
      chk("rst_if_gnt", {31'd0, if_gnt}, 32'd0);
      chk("rst_mem_en", {31'd0, mem_en}, 32'd0);
      chk("rst_mem_addr", mem_addr, 32'd0);
      chk("rst_mem_be", {28'd0, mem_be}, 32'd0);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_rvalid", {30'd0, if_rvalid, dm_rvalid}, 32'd0);
      chk("rst_rdata", if_rdata | dm_rdata, 32'd0);
      step();
      RESET = 1'b0;
      #1;
      // Single fetch: grant in the first cycle after reset.
      chk("fetch_gnt", {30'd0, if_gnt, dm_gnt}, 32'd2);
      chk("fetch_mem_addr", mem_addr, 32'h10);
      chk("fetch_mem_be", {28'd0, mem_be}, 32'hF);
      chk("fetch_mem_we", {31'd0, mem_we}, 32'd0);
      step(); if_req = 1'b0; #1;
      chk("fetch_t1_busy", {31'd0, busy}, 32'd1);
      chk("fetch_t1_rvalid", {31'd0, if_rvalid}, 32'd0);
      step();
      chk("fetch_t2_rvalid", {30'd0, if_rvalid, dm_rvalid}, 32'd2);
      chk("fetch_t2_rdata", if_rdata, 32'h00500093);
      chk("fetch_t2_busy", {31'd0, busy}, 32'd1);
      step();
      chk("fetch_t3_busy", {31'd0, busy}, 32'd0);
      chk("fetch_t3_rdata", if_rdata, 32'd0);

      // Simultaneous requests: data first, fetch granted alongside the data response.
      if_req = 1'b1; if_addr = 32'h14;
      dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h200; dm_be = 4'hF;
      #1;
      chk("sim_gnt", {30'd0, if_gnt, dm_gnt}, 32'd1);
      chk("sim_mem_addr", mem_addr, 32'h200);
      step(); dm_req = 1'b0; #1;
      chk("sim_wait_nogrant", {30'd0, if_gnt, dm_gnt}, 32'd0);
      step();
      chk("sim_dm_rvalid", {30'd0, if_rvalid, dm_rvalid}, 32'd1);
      chk("sim_dm_rdata", dm_rdata, 32'hCAFE0001);
      chk("sim_if_gnt", {31'd0, if_gnt}, 32'd1);
      chk("sim_mem_addr_if", mem_addr, 32'h14);
      step(); if_req = 1'b0; #1;
      step();
      chk("sim_if_rvalid", {30'd0, if_rvalid, dm_rvalid}, 32'd2);
      chk("sim_if_rdata", if_rdata, 32'h00A00113);
      step();

      // Write then back-to-back read of the same word.
      dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h40; dm_wdata = 32'hDEADBEEF; dm_be = 4'b0011;
      #1;
      chk("wr_gnt", {31'd0, dm_gnt}, 32'd1);
      chk("wr_mem_we", {31'd0, mem_we}, 32'd1);
      chk("wr_mem_be", {28'd0, mem_be}, 32'h3);
      chk("wr_mem_wdata", mem_wdata, 32'hDEADBEEF);
      step(); dm_req = 1'b0; #1;
      step();
      dm_req = 1'b1; dm_we = 1'b0; dm_wdata = 32'd0; dm_be = 4'hF;
      #1;
      chk("wr_rvalid", {31'd0, dm_rvalid}, 32'd1);
      chk("rd_gnt_in_resp", {31'd0, dm_gnt}, 32'd1);
      chk("rd_mem_we", {31'd0, mem_we}, 32'd0);
      step(); dm_req = 1'b0; #1;
      step();
      chk("rd_rvalid", {31'd0, dm_rvalid}, 32'd1);
      chk("rd_rdata", dm_rdata, 32'h0000BEEF);
      step();

      // Starvation guard with both requests held continuously.
      if_req = 1'b1; if_addr = 32'h10;
      dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h200; dm_be = 4'hF;
      #1;
      for (int k = 0; k < 10; k++) begin
         if (k == 4 || k == 9) begin
            chk($sformatf("starve_gnt%0d", k), {30'd0, if_gnt, dm_gnt}, 32'd2);
            chk($sformatf("starve_val%0d", k), {28'd0, dut.r_starve}, 32'd4);
         end else begin
            chk($sformatf("starve_gnt%0d", k), {30'd0, if_gnt, dm_gnt}, 32'd1);
         end
         step();
         if (k == 9) begin
            if_req = 1'b0; dm_req = 1'b0;
         end
         #1;
         if (k == 4 || k == 9)
            chk($sformatf("starve_clr%0d", k), {28'd0, dut.r_starve}, 32'd0);
         step();
      end
      step();
      chk("starve_idle_busy", {31'd0, busy}, 32'd0);

      // Reset mid-access abandons the response.
      if_req = 1'b1; if_addr = 32'h10;
      #1;
      chk("mid_gnt", {31'd0, if_gnt}, 32'd1);
      step(); if_req = 1'b0; RESET = 1'b1; #1;
      chk("mid_busy_before", {31'd0, busy}, 32'd1);
      step(); RESET = 1'b0; #1;
      chk("mid_rvalid", {30'd0, if_rvalid, dm_rvalid}, 32'd0);
      chk("mid_busy_after", {31'd0, busy}, 32'd0);
      chk("mid_state", {30'd0, 2'(dut.r_state)}, 32'd0);
      step();
      chk("mid_rvalid_late", {30'd0, if_rvalid, dm_rvalid}, 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
